// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte requesters, plus the baud strobe.
// Optional UART_SCHED_LOCK_EN: keep re-granting the last winner while it still requests.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int N_REQ    = 4,
  parameter int BAUD_DIV = 278
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   gnt,
  output logic               baud_ck,
  output logic [7:0]         tx_data,
  output logic               tx_we,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_READY} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [IDX_W-1:0] rr_last_reg;
  logic [IDX_W-1:0] rr_win;
  logic             rr_found;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [N_REQ-1:0] gnt_next;
  logic [7:0]       data_arr [N_REQ];

  // Free-running bit-period counter; the strobe is registered, so it lags count==last by one cycle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_reg <= '0;
      baud_ck      <= 1'b0;
    end else begin
      baud_ck      <= (baud_cnt_reg == CNT_LAST);
      baud_cnt_reg <= (baud_cnt_reg == CNT_LAST) ? '0 : baud_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_arr[gi] = data[gi*8 +: 8];
      assign gnt_next[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  // First set request scanning upward from the slot after the last winner.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] idx_v;
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    idx_v    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(rr_last_reg) + k) % N_REQ;
      idx_v = IDX_W'(idx);
      if (!rr_found && req[idx_v]) begin
        rr_found = 1'b1;
        rr_win   = idx_v;
      end
    end
  end

`ifdef UART_SCHED_LOCK_EN
  logic lock_reg;
  logic use_lock;

  assign use_lock  = lock_reg && req[rr_last_reg];
  assign win_idx   = use_lock ? rr_last_reg : rr_win;
  assign win_valid = use_lock || rr_found;

  // A grant (re)arms the lock; the holder releases it by dropping its request while we are idle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (tx_ready && win_valid)
        lock_reg <= 1'b1;
      else if (!req[rr_last_reg])
        lock_reg <= 1'b0;
    end
  end
`else
  assign win_idx   = rr_win;
  assign win_valid = rr_found;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt         <= '0;
      tx_we       <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      rr_last_reg <= IDX_LAST;
    end else begin
      tx_we <= 1'b0;
      gnt   <= '0;
      case (state_reg)
        IDLE: begin
          if (tx_ready && win_valid) begin
            tx_data     <= data_arr[win_idx];
            tx_we       <= 1'b1;
            gnt         <= gnt_next;
            rr_last_reg <= win_idx;
            busy        <= 1'b1;
            state_reg   <= WAIT_BUSY;
          end
        end
        // A uart_tx that never drops ready leaves us parked here by design.
        WAIT_BUSY: begin
          if (!tx_ready)
            state_reg <= WAIT_READY;
        end
        WAIT_READY: begin
          if (tx_ready) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx that serialises bytes on baud_ck.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int N_REQ    = 4;
  localparam int BAUD_DIV = 278;

  logic        ck    = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'h0;
  logic [31:0] data  = 32'h0;
  logic [3:0]  gnt;
  logic        baud_ck;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;

  always #5 ck = ~ck;

  uart_tx_sched #(.N_REQ(N_REQ), .BAUD_DIV(BAUD_DIV)) dut (
    .ck(ck), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt), .baud_ck(baud_ck),
    .tx_data(tx_data), .tx_we(tx_we), .tx_ready(tx_ready), .busy(busy)
  );

  // uart_tx stand-in: no reset, start bit then LSB first then stop, ready after the stop bit period.
  logic [9:0] m_shreg = 10'h3FF;
  int         m_cnt   = 0;
  logic       m_ready = 1'b1;
  bit         line_q[$];

  assign tx_ready = m_ready;

  always @(posedge ck) begin
    if (tx_we && m_ready) begin
      m_shreg <= {1'b1, tx_data, 1'b0};
      m_cnt   <= 10;
      m_ready <= 1'b0;
    end else if (baud_ck && !m_ready) begin
      if (m_cnt > 0) begin
        line_q.push_back(m_shreg[0]);
        m_shreg <= {1'b1, m_shreg[9:1]};
        m_cnt   <= m_cnt - 1;
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (rst_n) begin
      if (tx_we) begin
        we_count++;
        chk("ready_at_we", 32'(m_ready), 32'(1));
      end
      if (gnt != 4'h0 || tx_we) begin
        chk("gnt_onehot", 32'($countones(gnt)), 32'(1));
        chk("we_with_gnt", 32'(tx_we), 32'(1));
      end
    end
  end

  task automatic wait_we(output logic [3:0] g, output logic [7:0] d, output int n);
    n = 0;
    g = 4'h0;
    d = 8'h00;
    do begin
      @(negedge ck);
      n++;
    end while (!tx_we && n < 5000);
    if (!tx_we) begin
      chk("we_timeout", 32'(0), 32'(1));
    end else begin
      g = gnt;
      d = tx_data;
      $display("grant %b byte %02h after %0d cycles at %0t", g, d, n, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!(m_ready && !busy) && n < 5000);
    if (!(m_ready && !busy))
      chk("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_byte);
    logic [9:0] f = 10'h0;
    if (line_q.size() < 10) begin
      chk(tag, 32'(line_q.size()), 32'(10));
    end else begin
      for (int i = 0; i < 10; i++) f[i] = line_q.pop_front();
      $display("line frame %03h byte %02h", f, f[8:1]);
      chk(tag, 32'(f), 32'({1'b1, exp_byte, 1'b0}));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] g;
    logic [7:0] d;
    int         n;
    int         wc0;

    // Reset values and baud strobe spacing
    repeat (3) @(negedge ck);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_we", 32'(tx_we), 32'(0));
    chk("rst_data", 32'(tx_data), 32'(0));
    chk("rst_baud", 32'(baud_ck), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge ck); n++; end while (!baud_ck && n < 1000);
    chk("baud_first", 32'(n), 32'(BAUD_DIV));
    n = 0;
    do begin @(negedge ck); n++; end while (!baud_ck && n < 1000);
    chk("baud_period", 32'(n), 32'(BAUD_DIV));
    @(negedge ck);
    chk("baud_width", 32'(baud_ck), 32'(0));

    // Single requester, frame bits
    line_q.delete();
    data[7:0] = 8'hAA;
    req       = 4'b0001;
    wait_we(g, d, n);
    chk("single_latency", 32'(n), 32'(1));
    chk("single_gnt", 32'(g), 32'(4'b0001));
    chk("single_data", 32'(d), 32'(8'hAA));
    req = 4'b0000;
    @(negedge ck);
    chk("single_we_pulse", 32'(tx_we), 32'(0));
    chk("single_gnt_pulse", 32'(gnt), 32'(0));
    chk("single_busy", 32'(busy), 32'(1));
    wait_idle();
    check_frame("single_frame", 8'hAA);

`ifndef UART_SCHED_LOCK_EN
    // Contention: all four held, grants rotate from requester 0
    begin
      logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      do_reset();
      line_q.delete();
      data = 32'h13121110;
      req  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
        wait_we(g, d, n);
        chk("rr_gnt", 32'(g), 32'(exp_g[i]));
        chk("rr_data", 32'(d), 32'(exp_d[i]));
        if (i == 4) req = 4'b0000;
      end
      wait_idle();
      for (int i = 0; i < 5; i++) check_frame("rr_frame", exp_d[i]);
    end
`else
    // Lock: requester 1 sends three bytes unbroken despite requester 2 waiting
    do_reset();
    line_q.delete();
    data = {8'h00, 8'h40, 8'h31, 8'h00};
    req  = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      wait_we(g, d, n);
      chk("lock_gnt", 32'(g), 32'(4'b0010));
      chk("lock_data", 32'(d), 32'(8'h31 + i));
      if (i < 2) data[15:8] = 8'(8'h32 + i);
      else       req[1] = 1'b0;
    end
    wait_we(g, d, n);
    chk("lock_next_gnt", 32'(g), 32'(4'b0100));
    chk("lock_next_data", 32'(d), 32'(8'h40));
    req[2] = 1'b0;
    wait_idle();
    check_frame("lock_frame0", 8'h31);
    check_frame("lock_frame1", 8'h32);
    check_frame("lock_frame2", 8'h33);
    check_frame("lock_frame3", 8'h40);
`endif

    // Withdraw: a one-cycle request while busy leaves no trace
    line_q.delete();
    wc0       = we_count;
    data[7:0] = 8'h5A;
    req       = 4'b0001;
    wait_we(g, d, n);
    req = 4'b0000;
    repeat (100) @(negedge ck);
    chk("withdraw_busy", 32'(busy), 32'(1));
    data[31:24] = 8'hC3;
    req[3]      = 1'b1;
    @(negedge ck);
    req[3] = 1'b0;
    wait_idle();
    repeat (20) @(negedge ck);
    chk("withdraw_we_count", 32'(we_count - wc0), 32'(1));
    chk("withdraw_line_bits", 32'(line_q.size()), 32'(10));
    check_frame("withdraw_frame", 8'h5A);

    // Reset mid-frame: scheduler waits for uart_tx before the next byte
    line_q.delete();
    data[7:0] = 8'h3C;
    req       = 4'b0001;
    wait_we(g, d, n);
    data[7:0] = 8'h55;
    n = 0;
    while (line_q.size() < 4 && n < 5000) begin @(negedge ck); n++; end
    chk("midframe_reached", 32'(line_q.size() >= 4), 32'(1));
    rst_n = 1'b0;
    @(negedge ck);
    chk("midrst_we", 32'(tx_we), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_data", 32'(tx_data), 32'(0));
    @(negedge ck);
    rst_n = 1'b1;
    wait_we(g, d, n);
    chk("midrst_next_data", 32'(d), 32'(8'h55));
    chk("midrst_prev_done", 32'(line_q.size()), 32'(10));
    req = 4'b0000;
    wait_idle();
    check_frame("midrst_frame0", 8'h3C);
    check_frame("midrst_frame1", 8'h55);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
